// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
//   NOP_INSTR    : instruction returned whenever the fetch must not see memory
//                  (addi x0, x0, 0).
//   imem_state_t : load-control FSM states.
package common;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PAD     = 2'd2,
    RELEASE = 2'd3
  } imem_state_t;

endpackage

// File: rtl/instr_mem_responder_load_byte_packer.sv
// Collects program bytes, little-endian, into 32-bit words.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart packing (byte_idx and buffer to zero)
//   byte_en    : a byte is accepted this cycle
//   byte_in    : accepted byte
//   flush      : emit the partial buffer, unfilled upper lanes zeroed
//   byte_idx   : lane the next accepted byte lands in
//   word_valid : word is complete this cycle (4th byte or flush)
//   word       : word to store when word_valid is high
module load_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] buffer;
  logic [31:0] padded;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      buffer   <= 32'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
      buffer   <= 32'd0;
    end else if (byte_en) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      buffer[8*byte_idx +: 8] <= byte_in;
      byte_idx                <= byte_idx + 2'd1;
    end
  end

  // Lanes from a previous full word stay in the buffer, so the flush path
  // masks everything at or above byte_idx.
  always_comb begin
    // NOTE: assigning a default first keeps this block free of inferred latches.
    padded = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(byte_idx)) padded[8*i +: 8] = buffer[8*i +: 8];
    end
  end

  // The completing byte is merged directly so the word is stored on the same
  // edge that accepts it.
  assign word_valid = flush || (byte_en && (byte_idx == 2'd3));
  assign word       = flush ? padded : {byte_in, buffer[23:0]};

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory for the fetch stage with a byte-stream program loader.
//   clk, reset   : clock, asynchronous active-high reset
//   address      : fetch byte address; data is its instruction word (combinational)
//   load_start   : begin a program load (honoured only when idle)
//   load_byte/load_valid/load_last/load_ready : little-endian image stream
//   cpu_hold     : core stalls while a load is in progress
//   cpu_restart  : one-cycle pulse at the end of a load; core refetches from 0
//   load_error   : sticky, image was larger than the memory
//   word_count   : words written by the last load
module instr_mem_responder
  import common::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  address,
  output logic [31:0]                  data,
  input  logic                         load_start,
  input  logic [7:0]                   load_byte,
  input  logic                         load_valid,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         cpu_hold,
  output logic                         cpu_restart,
  output logic                         load_error,
  output logic [$clog2(DEPTH_WORDS):0] word_count
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  imem_state_t state_q, state_d;
  logic [AW:0] wr_ptr;
  logic        load_clear;
  logic        byte_accept;
  logic        pad_flush;
  logic [1:0]  byte_idx;
  logic        word_valid;
  logic [31:0] packed_word;
  logic        mem_full;
  logic        mem_we;
  logic [31:0] mem [DEPTH_WORDS];

  assign load_ready  = (state_q == LOAD);
  assign cpu_hold    = (state_q != IDLE);
  assign cpu_restart = (state_q == RELEASE);
  assign load_clear  = (state_q == IDLE) && load_start;
  assign byte_accept = load_valid && load_ready;
  assign pad_flush   = (state_q == PAD);

  load_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_clear),
    .byte_en    (byte_accept),
    .byte_in    (load_byte),
    .flush      (pad_flush),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  // wr_ptr stops at DEPTH_WORDS, so its top bit alone means "memory full".
  assign mem_full = wr_ptr[AW];
  assign mem_we   = word_valid && !mem_full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      // A last byte landing in lane 3 completes a word; otherwise pad it out.
      LOAD:    if (byte_accept && load_last) state_d = (byte_idx == 2'd3) ? RELEASE : PAD;
      PAD:     state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every stored word advances wr_ptr, so it doubles as the word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      load_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_clear) begin
        wr_ptr     <= '0;
        load_error <= 1'b0;
      end else if (word_valid) begin
        if (mem_full) load_error <= 1'b1;
        else          wr_ptr     <= wr_ptr + PTR_ONE;
      end
    end
  end

  assign word_count = wr_ptr;

  // NOTE: the memory array has no reset so it maps onto RAM; its contents
  // survive reset and load_start by design.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= packed_word;
  end

  always_comb begin
    if (cpu_hold || (address[1:0] != 2'b00) || (address[31:AW+2] != '0)) data = NOP_INSTR;
    else                                                                data = mem[address[AW+1:2]];
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
  import common::*;

  localparam int DEPTH = 4;

  typedef struct {
    int wc;
    int err;
    int delta;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        load_error;
  logic [2:0]  word_count;

  int checks   = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  bit          rd_en = 1'b0;
  logic [31:0] model_mem [DEPTH];
  bit          model_known [DEPTH];

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .data        (data),
    .load_start  (load_start),
    .load_byte   (load_byte),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .load_error  (load_error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    int   cyc      = 0;
    int   last_acc = 0;
    bit   post_chk = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        post_chk = 1'b0;
      end else begin
        if (post_chk) begin
          check("restart_one_cycle", 32'(cpu_restart), 32'd0);
          check("hold_low_after_release", 32'(cpu_hold), 32'd0);
          post_chk = 1'b0;
        end
        if (load_valid && load_ready) last_acc = cyc;
        if (cpu_hold) check("nop_while_hold", data, NOP_INSTR);
        if (cpu_restart) begin
          if (exp_q.size() == 0) begin
            check("unexpected_restart", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("word_count", 32'(word_count), 32'(e.wc));
            check("load_error", 32'(load_error), 32'(e.err));
            check("restart_latency", 32'(cyc - last_acc), 32'(e.delta));
            post_chk = 1'b1;
          end
        end
        if (rd_en) begin
          if (rd_q.size() == 0) check("read_without_expectation", 32'd1, 32'd0);
          else                  check("read_data", data, rd_q.pop_front());
        end
      end
    end
  end

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    address = addr;
    rd_q.push_back(exp);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic readback();
    for (int w = 0; w < DEPTH; w++) begin
      if (model_known[w]) read_check(32'(w * 4), model_mem[w]);
    end
    read_check(32'd2, NOP_INSTR);
    read_check(32'd16, NOP_INSTR);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(load_ready), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_restart"}, 32'(cpu_restart), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'd0);
    check({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  // abort_after < 0: complete load. Otherwise send that many bytes (no last)
  // and then assert reset mid-load.
  task automatic send_image(input logic [7:0] img[$], input int gap_pct,
                            input bit extra_start, input int abort_after);
    int          n;
    int          nb;
    int          words;
    int          idx;
    int          iter;
    int          t;
    bit          acc;
    logic [31:0] v;
    exp_t        e;
    n     = img.size();
    nb    = (abort_after >= 0) ? abort_after : n;
    words = (abort_after >= 0) ? nb / 4 : (n + 3) / 4;
    for (int w = 0; w < words && w < DEPTH; w++) begin
      v = 32'd0;
      for (int b = 0; b < 4; b++) if (4 * w + b < n) v[8*b +: 8] = img[4*w + b];
      model_mem[w]   = v;
      model_known[w] = 1'b1;
    end
    if (abort_after < 0) begin
      e.wc    = (words > DEPTH) ? DEPTH : words;
      e.err   = (words > DEPTH) ? 1 : 0;
      e.delta = (n % 4 == 0) ? 1 : 2;
      exp_q.push_back(e);
    end

    @(posedge clk);
    #1 load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    check("start_ready", 32'(load_ready), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_error_cleared", 32'(load_error), 32'd0);
    check("start_count_cleared", 32'(word_count), 32'd0);

    idx  = 0;
    iter = 0;
    while (idx < nb && iter < 500) begin
      address    = 32'($urandom_range(0, 7)) << 2;
      load_start = extra_start && (iter == 3);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        load_last  = 1'($urandom_range(0, 1));
      end else begin
        load_valid = 1'b1;
        load_byte  = img[idx];
        load_last  = (abort_after < 0) && (idx == n - 1);
      end
      acc = load_valid && load_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      iter++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
    check("bytes_accepted", 32'(idx), 32'(nb));

    if (abort_after >= 0) begin
      check("count_before_reset", 32'(word_count), 32'(words));
      #1 reset = 1'b1;
      #1 check_reset_outputs("async_reset");
      @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      t = 0;
      while (cpu_hold && t < 10) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("hold_released", 32'(cpu_hold), 32'd0);
    end
  endtask

  initial begin : driver
    logic [7:0] img[$];
    reset      = 1'b1;
    address    = 32'd0;
    load_start = 1'b0;
    load_byte  = 8'd0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int w = 0; w < DEPTH; w++) model_known[w] = 1'b0;
    #3 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Address decode independent of contents.
    read_check(32'd6, NOP_INSTR);
    read_check(32'h0000_0010, NOP_INSTR);
    read_check(32'h8000_0000, NOP_INSTR);

    // Aligned single-word image.
    img = '{8'h93, 8'h00, 8'hA0, 8'h00};
    send_image(img, 0, 1'b0, -1);
    readback();

    // Unaligned 5-byte image with gaps and an ignored second load_start.
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_image(img, 40, 1'b1, -1);
    readback();

    // Overflow: 20 bytes into a 4-word memory.
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    send_image(img, 20, 1'b0, -1);
    readback();

    // Reset after 6 bytes: one word written, the partial word dropped.
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    send_image(img, 30, 1'b0, 6);
    readback();

    // Fresh minimum (1-byte) load after the aborted one.
    img = '{8'hA5};
    send_image(img, 0, 1'b0, -1);
    readback();

    // Random images, including overflow and aligned/unaligned lengths.
    for (int k = 0; k < 10; k++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 22)); i++) img.push_back(8'($urandom));
      send_image(img, 30, 1'($urandom_range(0, 1)), -1);
      readback();
    end

    repeat (3) @(posedge clk);
    check("all_restarts_seen", 32'(exp_q.size()), 32'd0);
    check("all_reads_checked", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
